// File: rtl/orao_boot_pkg.sv
// Shared definitions for the Orao power-on boot sequencer: key actions, the
// fixed 12-step table and helpers that map a step index to its action/length.
package orao_boot_pkg;

    typedef enum logic [2:0] {
        ACT_RST   = 3'd0,
        ACT_IDLE  = 3'd1,
        ACT_B     = 3'd2,
        ACT_C     = 3'd3,
        ACT_ENTER = 3'd4
    } action_e;

    localparam int unsigned STEP_COUNT = 12;
    localparam logic [3:0]  STEP_DONE  = 4'd12;
    localparam logic [3:0]  STEP_LAST  = 4'd11;

    function automatic int unsigned clamp_len(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic action_e step_action(input logic [3:0] s);
        action_e act;
        case (s)
            4'd0:                    act = ACT_RST;
            4'd2:                    act = ACT_B;
            4'd4:                    act = ACT_C;
            4'd6, 4'd8, 4'd10:       act = ACT_ENTER;
            default:                 act = ACT_IDLE;
        endcase
        return act;
    endfunction

    // Length in ticks; anything outside the table (DONE) reports 1 so compares stay sane.
    function automatic int unsigned step_len(input logic [3:0] s,
                                             input int unsigned reset_len,
                                             input int unsigned settle_len,
                                             input int unsigned press_len,
                                             input int unsigned gap_len);
        int unsigned len;
        case (s)
            4'd0:                           len = reset_len;
            4'd1:                           len = settle_len;
            4'd2, 4'd4, 4'd6, 4'd8, 4'd10:  len = press_len;
            4'd3, 4'd5, 4'd7, 4'd9, 4'd11:  len = gap_len;
            default:                        len = 1;
        endcase
        return clamp_len(len);
    endfunction

endpackage

// File: rtl/orao_tick_div.sv
// Prescaler: counts 0..TICK_CYCLES-1 and flags the wrap cycle. clr restarts the
// count so the next tick lands exactly TICK_CYCLES cycles later.
module orao_tick_div #(
    parameter int unsigned TICK_CYCLES = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned TC = (TICK_CYCLES == 0) ? 1 : TICK_CYCLES;
    localparam int          CW = (TC > 1) ? $clog2(TC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TC - 1));
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/orao_boot_sequencer.sv
// Timed power-on stimulus for the Orao core: hold reset, settle, type B, C and
// ENTER x3, then idle in DONE until restart. Outputs are decoded from next state.
module orao_boot_sequencer
    import orao_boot_pkg::*;
#(
    parameter int unsigned clk_mhz      = 25,
    parameter int unsigned tick_cycles  = clk_mhz * 1000,
    parameter int unsigned reset_ticks  = 300,
    parameter int unsigned settle_ticks = 500,
    parameter int unsigned press_ticks  = 100,
    parameter int unsigned gap_ticks    = 200
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       restart,
    input  logic       skip,
    output logic       cpu_n_reset,
    output logic       key_b,
    output logic       key_c,
    output logic       key_enter,
    output logic       busy,
    output logic [3:0] step
);

    localparam int unsigned RST_L = clamp_len(reset_ticks);
    localparam int unsigned SET_L = clamp_len(settle_ticks);
    localparam int unsigned PRS_L = clamp_len(press_ticks);
    localparam int unsigned GAP_L = clamp_len(gap_ticks);
    localparam int unsigned MAX_L = max_u(max_u(RST_L, SET_L), max_u(PRS_L, GAP_L));
    localparam int          TW    = (MAX_L > 1) ? $clog2(MAX_L + 1) : 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          cpu_n_reset_q, cpu_n_reset_d;
    logic          key_b_q, key_b_d;
    logic          key_c_q, key_c_d;
    logic          key_enter_q, key_enter_d;
    logic          busy_q, busy_d;
    logic          tick;
    logic          div_clr;
    logic          last_tick;
    int unsigned   cur_len;
    action_e       nxt_act;

    orao_tick_div #(
        .TICK_CYCLES(tick_cycles)
    ) u_tick_div (
        .clk  (clk),
        .rst_n(n_reset),
        .clr  (div_clr),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tcnt_d    = tcnt_q;
        div_clr   = 1'b0;
        cur_len   = step_len(step_q, RST_L, SET_L, PRS_L, GAP_L);
        last_tick = tick && (tcnt_q == TW'(cur_len - 1));

        // restart outranks skip and works from any state
        if (restart) begin
            state_d = ST_RUN;
            step_d  = '0;
            tcnt_d  = '0;
            div_clr = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (skip) begin
                state_d = ST_DONE;
                step_d  = STEP_DONE;
                tcnt_d  = '0;
                div_clr = 1'b1;
            end else if (last_tick) begin
                tcnt_d  = '0;
                div_clr = 1'b1;
                if (step_q == STEP_LAST) begin
                    state_d = ST_DONE;
                    step_d  = STEP_DONE;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end else if (tick) begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end

        // Decode from the next step so outputs change on the same edge as step
        nxt_act       = step_action(step_d);
        cpu_n_reset_d = 1'b1;
        key_b_d       = 1'b0;
        key_c_d       = 1'b0;
        key_enter_d   = 1'b0;
        busy_d        = 1'b0;
        if (state_d == ST_RUN) begin
            busy_d        = 1'b1;
            cpu_n_reset_d = (nxt_act != ACT_RST);
            key_b_d       = (nxt_act == ACT_B);
            key_c_d       = (nxt_act == ACT_C);
            key_enter_d   = (nxt_act == ACT_ENTER);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_RUN;
            step_q        <= '0;
            tcnt_q        <= '0;
            cpu_n_reset_q <= 1'b0;
            key_b_q       <= 1'b0;
            key_c_q       <= 1'b0;
            key_enter_q   <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            tcnt_q        <= tcnt_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            key_b_q       <= key_b_d;
            key_c_q       <= key_c_d;
            key_enter_q   <= key_enter_d;
            busy_q        <= busy_d;
        end
    end

    assign cpu_n_reset = cpu_n_reset_q;
    assign key_b       = key_b_q;
    assign key_c       = key_c_q;
    assign key_enter   = key_enter_q;
    assign busy        = busy_q;
    assign step        = step_q;

endmodule
